// File: rtl/rob_pkg.sv
// Shared types for the N-wide reorder buffer: entry layout, default widths and a popcount helper.
package rob_pkg;

    localparam int ROB_PREG_W = 6;
    localparam int ROB_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  store;
        logic [ROB_PREG_W-1:0] rd;
        logic [ROB_PREG_W-1:0] old_rd;
        logic [ROB_DATA_W-1:0] value;
    } rob_entry_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Finds the run of valid&done entries starting at head (wrapping mod DEPTH), capped at COMMIT_W lanes.
module rob_commit_select #(
    parameter int DEPTH    = 16,
    parameter int COMMIT_W = 2,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic [TAG_W-1:0]    head,
    input  logic [DEPTH-1:0]    ready_vec,
    output logic [COMMIT_W-1:0] lane_valid,
    output logic [TAG_W:0]      n
);

    logic             run;
    logic [TAG_W-1:0] idx;

    always_comb begin
        run        = 1'b1;
        idx        = '0;
        n          = '0;
        lane_valid = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx           = head + TAG_W'(k);
            run           = run & ready_vec[idx];
            lane_valid[k] = run;
            n             = n + (TAG_W+1)'(run);
        end
    end

endmodule

// File: rtl/reorder_buffer_nw.sv
// N-wide reorder buffer: in-order allocate, out-of-order writeback, in-order commit and preg freeing.
// Optional ROB_FLUSH_EN adds a `flush` input that empties the buffer with priority over everything else.
module reorder_buffer_nw
    import rob_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DISP_W   = 2,
    parameter int WB_W     = 2,
    parameter int COMMIT_W = 2,
    parameter int PREG_W   = ROB_PREG_W,
    parameter int DATA_W   = ROB_DATA_W,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       res,
`ifdef ROB_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W*PREG_W-1:0]   disp_rd,
    input  logic [DISP_W*PREG_W-1:0]   disp_old_rd,
    input  logic [DISP_W-1:0]          disp_store,
    output logic                       disp_ready,
    output logic [DISP_W*TAG_W-1:0]    disp_tag,
    input  logic [WB_W-1:0]            wb_valid,
    input  logic [WB_W*TAG_W-1:0]      wb_tag,
    input  logic [WB_W*DATA_W-1:0]     wb_value,
    output logic [COMMIT_W-1:0]        com_valid,
    output logic [COMMIT_W-1:0]        com_wr_en,
    output logic [COMMIT_W*PREG_W-1:0] com_rd,
    output logic [COMMIT_W*DATA_W-1:0] com_value,
    output logic [COMMIT_W-1:0]        free_valid,
    output logic [COMMIT_W*PREG_W-1:0] free_preg,
    output logic [TAG_W:0]             count
);

    rob_entry_t          entries [DEPTH];
    logic [TAG_W-1:0]    head;
    logic [TAG_W-1:0]    tail;
    logic [TAG_W:0]      count_q;
    logic                kill;
    logic [DISP_W-1:0]   disp_acc;
    logic [TAG_W:0]      ndisp;
    logic [DEPTH-1:0]    ready_vec;
    logic [COMMIT_W-1:0] sel_valid;
    logic [TAG_W:0]      sel_n;

`ifdef ROB_FLUSH_EN
    assign kill = res | flush;
`else
    assign kill = res;
`endif

    assign count = count_q;

    // Handshake: a lane is taken on a cycle where disp_valid[i] && disp_ready; disp_ready is all-or-nothing
    // (DISP_W free slots from the registered count) so a same-cycle commit never widens the window.
    assign disp_ready = !kill && (((TAG_W+1)'(DEPTH) - count_q) >= (TAG_W+1)'(DISP_W));
    assign disp_acc   = disp_valid & {DISP_W{disp_ready}};
    assign ndisp      = (TAG_W+1)'(popcount(32'(disp_acc)));

    for (genvar i = 0; i < DISP_W; i++) begin : g_tag
        assign disp_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign ready_vec[i] = entries[i].valid & entries[i].done;
    end

    rob_commit_select #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W),
        .TAG_W    (TAG_W)
    ) u_sel (
        .head       (head),
        .ready_vec  (ready_vec),
        .lane_valid (sel_valid),
        .n          (sel_n)
    );

    assign com_valid = kill ? '0 : sel_valid;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_com
        logic [TAG_W-1:0] idx;
        assign idx = head + TAG_W'(k);
        assign com_rd[k*PREG_W +: PREG_W]    = com_valid[k] ? entries[idx].rd : '0;
        assign com_value[k*DATA_W +: DATA_W] = com_valid[k] ? entries[idx].value : '0;
        assign com_wr_en[k]  = com_valid[k] & ~entries[idx].store & (entries[idx].rd != '0);
        // x0 is never handed back to the free list.
        assign free_valid[k] = com_valid[k] & ~entries[idx].store & (entries[idx].old_rd != '0);
        assign free_preg[k*PREG_W +: PREG_W] = free_valid[k] ? entries[idx].old_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DISP_W; i++) begin
                if (disp_acc[i]) begin
                    entries[tail + TAG_W'(i)].valid  <= 1'b1;
                    entries[tail + TAG_W'(i)].done   <= 1'b0;
                    entries[tail + TAG_W'(i)].store  <= disp_store[i];
                    entries[tail + TAG_W'(i)].rd     <= disp_rd[i*PREG_W +: PREG_W];
                    entries[tail + TAG_W'(i)].old_rd <= disp_old_rd[i*PREG_W +: PREG_W];
                    entries[tail + TAG_W'(i)].value  <= '0;
                end
            end
            // Ascending port order lets the higher port win a same-tag collision.
            for (int p = 0; p < WB_W; p++) begin
                if (wb_valid[p] && entries[wb_tag[p*TAG_W +: TAG_W]].valid) begin
                    entries[wb_tag[p*TAG_W +: TAG_W]].done  <= 1'b1;
                    entries[wb_tag[p*TAG_W +: TAG_W]].value <= wb_value[p*DATA_W +: DATA_W];
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (sel_valid[k]) begin
                    entries[head + TAG_W'(k)].valid <= 1'b0;
                    entries[head + TAG_W'(k)].done  <= 1'b0;
                end
            end
            head    <= head + sel_n[TAG_W-1:0];
            tail    <= tail + ndisp[TAG_W-1:0];
            count_q <= count_q + ndisp - sel_n;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!kill) begin
            for (int i = 1; i < DISP_W; i++) begin
                assert (!(disp_valid[i] && !disp_valid[i-1]))
                    else $error("rob: dispatch lanes are not a prefix");
            end
            for (int p = 0; p < WB_W; p++) begin
                if (wb_valid[p]) begin
                    assert (entries[wb_tag[p*TAG_W +: TAG_W]].valid)
                        else $error("rob: writeback to empty entry");
                    assert (!(entries[wb_tag[p*TAG_W +: TAG_W]].valid && entries[wb_tag[p*TAG_W +: TAG_W]].done))
                        else $error("rob: writeback to an already completed entry");
                    for (int q = p + 1; q < WB_W; q++) begin
                        assert (!(wb_valid[q] && (wb_tag[q*TAG_W +: TAG_W] == wb_tag[p*TAG_W +: TAG_W])))
                            else $error("rob: two writeback ports hit the same tag");
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer_nw.sv
// Directed bench for reorder_buffer_nw: dispatch pushes expected commit records, a negedge monitor pops them.
module tb_reorder_buffer_nw;

    localparam int DEPTH    = 16;
    localparam int DISP_W   = 2;
    localparam int WB_W     = 2;
    localparam int COMMIT_W = 2;
    localparam int PREG_W   = 6;
    localparam int DATA_W   = 64;
    localparam int TAG_W    = 4;
    localparam int REC_W    = 1 + 2*PREG_W + DATA_W;

    logic                       clk;
    logic                       res;
`ifdef ROB_FLUSH_EN
    logic                       flush;
`endif
    logic [DISP_W-1:0]          disp_valid;
    logic [DISP_W*PREG_W-1:0]   disp_rd;
    logic [DISP_W*PREG_W-1:0]   disp_old_rd;
    logic [DISP_W-1:0]          disp_store;
    logic                       disp_ready;
    logic [DISP_W*TAG_W-1:0]    disp_tag;
    logic [WB_W-1:0]            wb_valid;
    logic [WB_W*TAG_W-1:0]      wb_tag;
    logic [WB_W*DATA_W-1:0]     wb_value;
    logic [COMMIT_W-1:0]        com_valid;
    logic [COMMIT_W-1:0]        com_wr_en;
    logic [COMMIT_W*PREG_W-1:0] com_rd;
    logic [COMMIT_W*DATA_W-1:0] com_value;
    logic [COMMIT_W-1:0]        free_valid;
    logic [COMMIT_W*PREG_W-1:0] free_preg;
    logic [TAG_W:0]             count;

    logic [REC_W-1:0]  exp_q[$];
    logic [TAG_W-1:0]  tag_q[$];
    logic [DATA_W-1:0] val_of_tag [DEPTH];
    logic [TAG_W-1:0]  m_tail;
    int                seq;
    int                errors;
    int                checks;

    reorder_buffer_nw #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .WB_W(WB_W), .COMMIT_W(COMMIT_W),
        .PREG_W(PREG_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .res(res),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .disp_valid(disp_valid),
        .disp_rd(disp_rd),
        .disp_old_rd(disp_old_rd),
        .disp_store(disp_store),
        .disp_ready(disp_ready),
        .disp_tag(disp_tag),
        .wb_valid(wb_valid),
        .wb_tag(wb_tag),
        .wb_value(wb_value),
        .com_valid(com_valid),
        .com_wr_en(com_wr_en),
        .com_rd(com_rd),
        .com_value(com_value),
        .free_valid(free_valid),
        .free_preg(free_preg),
        .count(count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
        disp_valid = '0;
        wb_valid   = '0;
`ifdef ROB_FLUSH_EN
        flush      = 1'b0;
`endif
    endtask

    task automatic set_disp(input int nl,
                            input logic [PREG_W-1:0] rd0, input logic [PREG_W-1:0] old0, input logic st0,
                            input logic [PREG_W-1:0] rd1, input logic [PREG_W-1:0] old1, input logic st1,
                            input logic exp_acc);
        logic [PREG_W-1:0] rd, old;
        logic              st;
        logic [DATA_W-1:0] val;
        disp_valid  = (nl == 2) ? 2'b11 : 2'b01;
        disp_rd     = {rd1, rd0};
        disp_old_rd = {old1, old0};
        disp_store  = {st1, st0};
        #1;
        chk("disp_ready", 64'(disp_ready), 64'(exp_acc));
        if (exp_acc) begin
            for (int i = 0; i < nl; i++) begin
                rd  = (i == 0) ? rd0 : rd1;
                old = (i == 0) ? old0 : old1;
                st  = (i == 0) ? st0 : st1;
                chk("disp_tag", 64'(disp_tag[i*TAG_W +: TAG_W]), 64'(m_tail));
                val = {32'hC0DE_0000, 32'(seq)};
                seq++;
                val_of_tag[m_tail] = val;
                tag_q.push_back(m_tail);
                exp_q.push_back({st, rd, old, val});
                m_tail = m_tail + 1'b1;
            end
        end
    endtask

    task automatic drive_wb(input int p, input logic [TAG_W-1:0] t);
        wb_valid[p]                  = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]     = t;
        wb_value[p*DATA_W +: DATA_W] = val_of_tag[t];
    endtask

    task automatic set_wb(input int n);
        for (int p = 0; p < n; p++) begin
            if (tag_q.size() != 0) drive_wb(p, tag_q.pop_front());
        end
    endtask

    task automatic drain(input string name);
        for (int b = 0; b < 60 && (count != 0 || exp_q.size() != 0 || tag_q.size() != 0); b++) begin
            set_wb(2);
            cyc();
        end
        chk({name, "_count"}, 64'(count), 64'd0);
        chk({name, "_expq"}, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [REC_W-1:0]  rec;
        logic              st;
        logic [PREG_W-1:0] rd, old;
        logic [DATA_W-1:0] val;
        if (!res) begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (com_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: lane %0d rd=%0d, expected no commit", k,
                                 com_rd[k*PREG_W +: PREG_W]);
                    end else begin
                        rec = exp_q.pop_front();
                        st  = rec[REC_W-1];
                        rd  = rec[REC_W-2 -: PREG_W];
                        old = rec[DATA_W +: PREG_W];
                        val = rec[DATA_W-1:0];
                        chk("com_rd", 64'(com_rd[k*PREG_W +: PREG_W]), 64'(rd));
                        chk("com_value", com_value[k*DATA_W +: DATA_W], val);
                        chk("com_wr_en", 64'(com_wr_en[k]), 64'(!st && rd != 0));
                        chk("free_valid", 64'(free_valid[k]), 64'(!st && old != 0));
                        if (!st && old != 0) chk("free_preg", 64'(free_preg[k*PREG_W +: PREG_W]), 64'(old));
                    end
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0; seq = 0; m_tail = '0;
        res = 1'b1;
        disp_valid = '0; disp_rd = '0; disp_old_rd = '0; disp_store = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif

        // 1: reset
        cyc();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd0);
        cyc();
        chk("rst_ready2", 64'(disp_ready), 64'd0);
        chk("rst_com_valid", 64'(com_valid), 64'd0);
        chk("rst_free_valid", 64'(free_valid), 64'd0);
        res = 1'b0;
        #1;
        chk("post_rst_ready", 64'(disp_ready), 64'd1);

        // 2: out-of-order writeback, in-order dual commit
        set_disp(2, 6'd33, 6'd1, 1'b0, 6'd34, 6'd2, 1'b0, 1'b1);
        cyc();
        chk("t2_count", 64'(count), 64'd2);
        drive_wb(0, 4'd1);
        tag_q.delete();
        cyc();
        @(negedge clk);
        chk("t2_no_commit", 64'(com_valid), 64'd0);
        drive_wb(0, 4'd0);
        cyc();
        @(negedge clk);
        chk("t2_both_commit", 64'(com_valid), 64'b11);
        chk("t2_free_preg", 64'(free_preg), 64'({6'd2, 6'd1}));
        cyc();
        chk("t2_empty", 64'(count), 64'd0);

        // 3: fill to DEPTH, overflow ignored, ready returns after commit
        for (int i = 0; i < 8; i++) begin
            set_disp(2, 6'(10 + 2*i), 6'(20 + 2*i), 1'b0, 6'(11 + 2*i), 6'(21 + 2*i), 1'b0, 1'b1);
            cyc();
        end
        chk("t3_full", 64'(count), 64'd16);
        set_disp(2, 6'd50, 6'd51, 1'b0, 6'd52, 6'd53, 1'b0, 1'b0);
        cyc();
        chk("t3_still_full", 64'(count), 64'd16);
        set_wb(2);
        cyc();
        @(negedge clk);
        chk("t3_commit2", 64'(com_valid), 64'b11);
        chk("t3_ready_same_cycle", 64'(disp_ready), 64'd0);
        cyc();
        chk("t3_count14", 64'(count), 64'd14);
        chk("t3_ready_back", 64'(disp_ready), 64'd1);
        drain("t3_drain");

        // 4: wrap-around streaming
        for (int i = 0; i < 40; i++) begin
            set_disp(2, 6'(2 + (2*i) % 60), 6'(3 + i % 50), 1'b0, 6'(3 + (2*i) % 60), 6'(4 + i % 50), 1'b0, 1'b1);
            if (i > 0) set_wb(2);
            cyc();
            chk("t4_count_bound", 64'(count <= 16), 64'd1);
        end
        drain("t4_drain");

        // 5: store and rd=0/old_rd=0 entries
        set_disp(2, 6'd7, 6'd5, 1'b1, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc();
        drain("t5_drain");

`ifdef ROB_FLUSH_EN
        // 6: flush with partially completed entries
        for (int i = 0; i < 3; i++) begin
            set_disp(2, 6'(40 + 2*i), 6'(8 + 2*i), 1'b0, 6'(41 + 2*i), 6'(9 + 2*i), 1'b0, 1'b1);
            cyc();
        end
        drive_wb(0, tag_q[1]);
        drive_wb(1, tag_q[2]);
        cyc();
        drive_wb(0, tag_q[0]);
        cyc();
        flush = 1'b1;
        #1;
        chk("t6_flush_com", 64'(com_valid), 64'd0);
        chk("t6_flush_free", 64'(free_valid), 64'd0);
        cyc();
        chk("t6_count", 64'(count), 64'd0);
        exp_q.delete();
        tag_q.delete();
        m_tail = '0;
        set_disp(2, 6'd12, 6'd13, 1'b0, 6'd14, 6'd15, 1'b0, 1'b1);
        cyc();
        drain("t6_drain");
`endif

        // 7: reset mid-operation issues no frees
        set_disp(2, 6'd44, 6'd45, 1'b0, 6'd46, 6'd47, 1'b0, 1'b1);
        cyc();
        set_wb(2);
        cyc();
        res = 1'b1;
        #1;
        chk("t7_rst_com", 64'(com_valid), 64'd0);
        chk("t7_rst_free", 64'(free_valid), 64'd0);
        chk("t7_rst_ready", 64'(disp_ready), 64'd0);
        cyc();
        chk("t7_count", 64'(count), 64'd0);
        res = 1'b0;
        exp_q.delete();
        tag_q.delete();
        m_tail = '0;
        set_disp(1, 6'd9, 6'd10, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc();
        drain("t7_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
